// File: rtl/reg_file_sb_pkg.sv
// Shared widths and types for the 2R/2W register file with pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on writeback, popcounted.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              hit_a,
  input  logic              hit_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Issue is applied last so a younger producer survives a same-cycle writeback.
  always_comb begin
    pending_nxt = pending;
    if (wr0_en) pending_nxt[wr0_addr] = 1'b0;
    if (wr1_en) pending_nxt[wr1_addr] = 1'b0;
    if (issue_en) pending_nxt[issue_addr] = 1'b1;
    if (ZERO_REG != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // A bypassed write satisfies the read this cycle, so it is not busy.
  assign busy_a = pending[rd_addr_a] & ~hit_a;
  assign busy_b = pending[rd_addr_b] & ~hit_b;

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pend_cnt = pend_cnt + (ADDR_W + 1)'(pending[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/two-write register file with write-to-read bypass and pending-write scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  logic zero_en;
  logic byp_en;
  logic wr0_act;
  logic wr1_act;
  logic hit0_a;
  logic hit1_a;
  logic hit0_b;
  logic hit1_b;

  assign zero_en = (ZERO_REG != 0);
  // Bypass is gated by reset so reads stay zero while rst_n is low.
  assign byp_en  = (BYPASS != 0) & rst_n;

  assign wr0_act = wr0_en & ~(zero_en & (wr0_addr == '0));
  assign wr1_act = wr1_en & ~(zero_en & (wr1_addr == '0));

  assign hit0_a = byp_en & wr0_act & (wr0_addr == rd_addr_a);
  assign hit1_a = byp_en & wr1_act & (wr1_addr == rd_addr_a);
  assign hit0_b = byp_en & wr0_act & (wr0_addr == rd_addr_b);
  assign hit1_b = byp_en & wr1_act & (wr1_addr == rd_addr_b);

  // Port 1 is applied after port 0 so it wins on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_act) regs[wr0_addr] <= wr0_data;
      if (wr1_act) regs[wr1_addr] <= wr1_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (hit0_a) rd_data_a = wr0_data;
    if (hit1_a) rd_data_a = wr1_data;
    if (zero_en && (rd_addr_a == '0)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (hit0_b) rd_data_b = wr0_data;
    if (hit1_b) rd_data_b = wr1_data;
    if (zero_en && (rd_addr_b == '0)) rd_data_b = '0;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .hit_a      (hit0_a | hit1_a),
    .hit_b      (hit0_b | hit1_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .pend_cnt   (pend_cnt)
  );

endmodule
